hamming_decoder_periph: RTL

//  Receive-side counterpart of the Hamming encoder peripheral.
//  - CPU writes one 32-bit word of four SECDED(8,4) codewords.
//  - An FSM decodes one codeword (lane) per cycle, correcting single-bit errors and flagging double-bit errors.
//  - The 16-bit result and per-lane flags are assembled into a read-only result register.
//  - Same register-select bus as the encoder: reg_sel_i=0 selects the input register, reg_sel_i=1 the result register.

---
 rtl/hamming_pkg.sv | 29 ++
 rtl/hamming_secded_dec.sv | 39 +++
 rtl/hamming_decoder_periph.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED(8,4) decoder peripheral.
package hamming_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        DECODE = 1'b1
    } state_t;

    localparam int unsigned DATA_W = 4;

    // Hamming positions (1-based) of the parity bits; each is also its syndrome weight.
    localparam int unsigned P1_POS = 1;
    localparam int unsigned P2_POS = 2;
    localparam int unsigned P4_POS = 4;

    // Hamming positions (1-based) of the data bits; byte bit = position - 1.
    localparam int unsigned D0_POS = 3;
    localparam int unsigned D1_POS = 5;
    localparam int unsigned D2_POS = 6;
    localparam int unsigned D3_POS = 7;

    // Result register field offsets.
    localparam int unsigned COR_LSB  = 16;
    localparam int unsigned UNC_LSB  = 20;
    localparam int unsigned OVR_BIT  = 29;
    localparam int unsigned BUSY_BIT = 30;
    localparam int unsigned DONE_BIT = 31;

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED(8,4) decoder for one codeword byte.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [7:0]        cw,
    output logic [DATA_W-1:0] data,
    output logic              corrected,
    output logic              uncorrectable
);

    logic [2:0] syn;
    logic       par;
    logic [7:1] pos;

    // Syndrome, overall parity, single-bit repair and data extraction.
    always_comb begin
        syn = '0;
        for (int unsigned i = 1; i <= 7; i++) begin
            if ((i & P1_POS) != 0) syn[0] = syn[0] ^ cw[i-1];
            if ((i & P2_POS) != 0) syn[1] = syn[1] ^ cw[i-1];
            if ((i & P4_POS) != 0) syn[2] = syn[2] ^ cw[i-1];
        end
        par = ^cw;

        // An odd-weight error with a nonzero syndrome points at the flipped position;
        // a zero syndrome means only the overall parity bit was hit.
        pos = cw[6:0];
        if (par) begin
            for (int unsigned i = 1; i <= 7; i++) begin
                if (syn == 3'(i)) pos[i] = ~pos[i];
            end
        end

        data          = {pos[D3_POS], pos[D2_POS], pos[D1_POS], pos[D0_POS]};
        corrected     = par;
        uncorrectable = !par && (syn != '0);
    end

endmodule

// File: rtl/hamming_decoder_periph.sv
// Register-mapped SECDED(8,4) decoder: one written word, one lane decoded per cycle.
module hamming_decoder_periph
    import hamming_pkg::*;
#(
    parameter int unsigned LANES = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_i,
    input  logic        reg_sel_i,
    input  logic [31:0] entrada_i,
    output logic [31:0] salida_o
);

    localparam logic [1:0] LAST_CNT = 2'(LANES - 1);

    state_t              state;
    state_t              state_next;
    logic [1:0]          cnt;
    logic [31:0]         in_reg;
    logic [4*DATA_W-1:0] data_reg;
    logic [3:0]          cor_reg;
    logic [3:0]          unc_reg;
    logic                ovr;
    logic                busy;
    logic                done;

    logic                accept;
    logic                drop;
    logic                last;
    logic [7:0]          lane_cw;
    logic [DATA_W-1:0]   lane_data;
    logic                lane_cor;
    logic                lane_unc;
    logic [31:0]         result;

    // The single decoder instance is steered to the current lane by the counter.
    assign lane_cw = in_reg[{cnt, 3'b000} +: 8];

    hamming_secded_dec u_dec (
        .cw            (lane_cw),
        .data          (lane_data),
        .corrected     (lane_cor),
        .uncorrectable (lane_unc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // FSM next-state: a write to the input register starts decoding; the last lane ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_i && !reg_sel_i) state_next = DECODE;
            DECODE:  if (cnt == LAST_CNT)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: accepted write, dropped write, last-lane strobe.
    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        last   = 1'b0;
        case (state)
            IDLE:   accept = wr_i && !reg_sel_i;
            DECODE: begin
                drop = wr_i && !reg_sel_i;
                last = (cnt == LAST_CNT);
            end
            default: ;
        endcase
    end

    // Input/result registers and lane counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_reg   <= '0;
            data_reg <= '0;
            cor_reg  <= '0;
            unc_reg  <= '0;
            ovr      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            in_reg   <= entrada_i;
            data_reg <= '0;
            cor_reg  <= '0;
            unc_reg  <= '0;
            ovr      <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            cnt      <= '0;
        end else if (state == DECODE) begin
            data_reg[{cnt, 2'b00} +: DATA_W] <= lane_data;
            cor_reg[cnt] <= lane_cor;
            unc_reg[cnt] <= lane_unc;
            if (drop) ovr <= 1'b1;
            if (last) begin
                busy <= 1'b0;
                done <= 1'b1;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    // Result register assembly and read mux.
    always_comb begin
        result                    = '0;
        result[4*DATA_W-1:0]      = data_reg;
        result[COR_LSB +: 4]      = cor_reg;
        result[UNC_LSB +: 4]      = unc_reg;
        result[OVR_BIT]           = ovr;
        result[BUSY_BIT]          = busy;
        result[DONE_BIT]          = done;
        salida_o = reg_sel_i ? result : in_reg;
    end

endmodule
